// File: rtl/axi_read_resp.sv
// AXI4 read-channel subordinate: 4-deep AR queue feeding an in-order burst walker
// that reads a synchronous word memory one beat at a time and returns R beats.
module axi_read_resp #(
  parameter int ARID_WIDTH   = 4,
  parameter int ARADDR_WIDTH = 10,
  parameter int RDATA_WIDTH  = 64,
  parameter int MEM_WORDS    = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [ARID_WIDTH-1:0]                        ARID,
  input  logic [ARADDR_WIDTH-1:0]                      ARADDR,
  input  logic [7:0]                                   ARLEN,
  input  logic [2:0]                                   ARSIZE,
  input  logic [1:0]                                   ARBURST,
  input  logic                                         ARVALID,
  output logic                                         ARREADY,
  output logic [ARID_WIDTH-1:0]                        RID,
  output logic [RDATA_WIDTH-1:0]                       RDATA,
  output logic [1:0]                                   RRESP,
  output logic                                         RLAST,
  output logic                                         RVALID,
  input  logic                                         RREADY,
  output logic                                         mem_rd_en,
  output logic [ARADDR_WIDTH-$clog2(RDATA_WIDTH/8)-1:0] mem_rd_addr,
  input  logic [RDATA_WIDTH-1:0]                       mem_rd_data
);

  localparam int BPW   = RDATA_WIDTH / 8;
  localparam int WSH   = $clog2(BPW);
  localparam int IDX_W = ARADDR_WIDTH - WSH;
  localparam logic [2:0]     WSH_L       = 3'(WSH);
  localparam logic [IDX_W:0] MEM_WORDS_L = (IDX_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, SEND = 2'd3} state_t;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ARADDR_WIDTH-1:0] a);
    return a[ARADDR_WIDTH-1:WSH];
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < MEM_WORDS_L);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size > WSH_L) | burst[1];
  endfunction

  logic [ARID_WIDTH-1:0]   q_id_r    [4];
  logic [ARADDR_WIDTH-1:0] q_addr_r  [4];
  logic [7:0]              q_len_r   [4];
  logic [2:0]              q_size_r  [4];
  logic [1:0]              q_burst_r [4];
  logic [1:0]              wr_ptr_r, rd_ptr_r;
  logic [2:0]              count_r, count_nxt_s;
  logic                    avail_r, arready_r;
  logic                    push_s, pop_s, rd_ok_s;

  state_t                  state_r, state_nxt_s;
  logic [ARID_WIDTH-1:0]   cur_id_r, cur_id_nxt_s;
  logic [ARADDR_WIDTH-1:0] cur_addr_r, cur_addr_nxt_s;
  logic [7:0]              len_r, len_nxt_s, beat_r, beat_nxt_s;
  logic [2:0]              size_r, size_nxt_s;
  logic [1:0]              burst_r, burst_nxt_s;
  logic                    err_r, err_nxt_s;
  logic                    rvalid_r, rvalid_nxt_s, rlast_r, rlast_nxt_s;
  logic [RDATA_WIDTH-1:0]  rdata_r, rdata_nxt_s;
  logic [1:0]              rresp_r, rresp_nxt_s;
  logic [ARID_WIDTH-1:0]   rid_r, rid_nxt_s;
  logic                    mem_rd_en_r, mem_rd_en_nxt_s;
  logic [IDX_W-1:0]        mem_rd_addr_r, mem_rd_addr_nxt_s;

  assign push_s  = ARVALID & arready_r;
  // The FSM sees queue occupancy through avail_r, one cycle behind the push.
  assign pop_s   = (state_r == IDLE) & avail_r & (count_r != 3'd0);
  assign rd_ok_s = ~err_r & in_range(word_idx(cur_addr_r));

  assign ARREADY     = arready_r;
  assign RID         = rid_r;
  assign RDATA       = rdata_r;
  assign RRESP       = rresp_r;
  assign RLAST       = rlast_r;
  assign RVALID      = rvalid_r;
  assign mem_rd_en   = mem_rd_en_r;
  assign mem_rd_addr = mem_rd_addr_r;

  // Queue occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 3'd1;
      2'b01:   count_nxt_s = count_r - 3'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue payload storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_id_r[wr_ptr_r]    <= ARID;
      q_addr_r[wr_ptr_r]  <= ARADDR;
      q_len_r[wr_ptr_r]   <= ARLEN;
      q_size_r[wr_ptr_r]  <= ARSIZE;
      q_burst_r[wr_ptr_r] <= ARBURST;
    end
  end

  // Queue pointers, count and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      count_r   <= 3'd0;
      avail_r   <= 1'b0;
      arready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 2'd1;
      count_r   <= count_nxt_s;
      avail_r   <= (count_r != 3'd0);
      arready_r <= (count_nxt_s != 3'd4);
    end
  end

  // Burst walker: next state, next burst context and next R/memory outputs
  always_comb begin
    state_nxt_s    = state_r;
    cur_id_nxt_s   = cur_id_r;
    cur_addr_nxt_s = cur_addr_r;
    len_nxt_s      = len_r;
    size_nxt_s     = size_r;
    burst_nxt_s    = burst_r;
    err_nxt_s      = err_r;
    beat_nxt_s     = beat_r;
    rvalid_nxt_s   = rvalid_r;
    rlast_nxt_s    = rlast_r;
    rdata_nxt_s    = rdata_r;
    rresp_nxt_s    = rresp_r;
    rid_nxt_s      = rid_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          cur_id_nxt_s   = q_id_r[rd_ptr_r];
          cur_addr_nxt_s = q_addr_r[rd_ptr_r];
          len_nxt_s      = q_len_r[rd_ptr_r];
          size_nxt_s     = q_size_r[rd_ptr_r];
          burst_nxt_s    = q_burst_r[rd_ptr_r];
          err_nxt_s      = burst_err(q_size_r[rd_ptr_r], q_burst_r[rd_ptr_r]);
          beat_nxt_s     = 8'd0;
          state_nxt_s    = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: state_nxt_s = WAIT;
      WAIT: begin
        rdata_nxt_s  = rd_ok_s ? mem_rd_data : {RDATA_WIDTH{1'b0}};
        rresp_nxt_s  = rd_ok_s ? 2'b00 : 2'b10;
        rid_nxt_s    = cur_id_r;
        rlast_nxt_s  = (beat_r == len_r);
        rvalid_nxt_s = 1'b1;
        state_nxt_s  = SEND;
      end
      SEND: begin
        if (RREADY) begin
          rvalid_nxt_s = 1'b0;
          if (rlast_r) begin
            state_nxt_s = IDLE;
          end else begin
            beat_nxt_s = beat_r + 8'd1;
            if (burst_r == 2'b01) begin
              cur_addr_nxt_s = cur_addr_r + (ARADDR_WIDTH'(1) << size_r);
            end else begin
              cur_addr_nxt_s = cur_addr_r;
            end
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    // Read strobe is registered so it is high exactly for the FETCH cycle
    mem_rd_addr_nxt_s = mem_rd_addr_r;
    if (state_nxt_s == FETCH) begin
      mem_rd_addr_nxt_s = word_idx(cur_addr_nxt_s);
      mem_rd_en_nxt_s   = ~err_nxt_s & in_range(word_idx(cur_addr_nxt_s));
    end else begin
      mem_rd_en_nxt_s = 1'b0;
    end
  end

  // Burst context, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cur_id_r      <= {ARID_WIDTH{1'b0}};
      cur_addr_r    <= {ARADDR_WIDTH{1'b0}};
      len_r         <= 8'd0;
      size_r        <= 3'd0;
      burst_r       <= 2'd0;
      err_r         <= 1'b0;
      beat_r        <= 8'd0;
      rvalid_r      <= 1'b0;
      rlast_r       <= 1'b0;
      rdata_r       <= {RDATA_WIDTH{1'b0}};
      rresp_r       <= 2'b00;
      rid_r         <= {ARID_WIDTH{1'b0}};
      mem_rd_en_r   <= 1'b0;
      mem_rd_addr_r <= {IDX_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      cur_id_r      <= cur_id_nxt_s;
      cur_addr_r    <= cur_addr_nxt_s;
      len_r         <= len_nxt_s;
      size_r        <= size_nxt_s;
      burst_r       <= burst_nxt_s;
      err_r         <= err_nxt_s;
      beat_r        <= beat_nxt_s;
      rvalid_r      <= rvalid_nxt_s;
      rlast_r       <= rlast_nxt_s;
      rdata_r       <= rdata_nxt_s;
      rresp_r       <= rresp_nxt_s;
      rid_r         <= rid_nxt_s;
      mem_rd_en_r   <= mem_rd_en_nxt_s;
      mem_rd_addr_r <= mem_rd_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_axi_read_resp.sv
// Scoreboard bench for axi_read_resp: directed AR requests push hand-computed
// beats; a negedge monitor pops and compares every accepted R beat.
module tb_axi_read_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ARID;
  logic [9:0]  ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_rd_en;
  logic [6:0]  mem_rd_addr;
  logic [63:0] mem_rd_data = 64'd0;

  always #5 clk = ~clk;

  axi_read_resp dut (
    .clk(clk), .rst_n(rst_n),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  // Word memory: word i holds value i
  logic [63:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 64'(i);
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= (mem_rd_addr < 7'd64) ? mem[mem_rd_addr[5:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          rise_q[$];
  int          acc_q[$];
  logic [6:0]  rd_addr_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          acc_total = 0;
  logic        stall_pend = 1'b0;
  logic        rv_prev = 1'b0;
  logic [79:0] held;
  beat_t       e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] r, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.resp = r; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic clear_logs();
    rise_q.delete(); acc_q.delete(); rd_addr_q.delete(); rd_cnt = 0;
  endtask

  // Monitor: scoreboard pop on accepted beats, hold-stable checks while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
      rv_prev    = 1'b0;
    end else begin
      if (stall_pend) check("stall_hold", 80'({RVALID, RID, RRESP, RLAST, RDATA}), held);
      if (RVALID && !rv_prev) rise_q.push_back(cyc);
      rv_prev = RVALID;
      if (RVALID && RREADY) begin
        acc_q.push_back(cyc);
        acc_total++;
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_beat: got id %0h data %0h with no beat expected", RID, RDATA);
        end else begin
          e = exp_q.pop_front();
          check("r_beat", 80'({RID, RRESP, RLAST, RDATA}), 80'({e.id, e.resp, e.last, e.data}));
        end
      end
      stall_pend = RVALID && !RREADY;
      held = 80'({RVALID, RID, RRESP, RLAST, RDATA});
      if (mem_rd_en) begin
        rd_cnt++;
        rd_addr_q.push_back(mem_rd_addr);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the handshake edge
  task automatic send_ar(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs);
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!ARREADY) begin
      compared++; mismatched++;
      $display("FAIL ar_timeout: got ARREADY 0 expected 1 within 200 cycles");
      hs = -1;
    end else begin
      @(posedge clk); #1;
      hs = cyc;
    end
    ARVALID = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int limit);
    int n = 0;
    while (!RVALID && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (!RVALID) begin
      compared++; mismatched++;
      $display("FAIL rvalid_timeout: got RVALID 0 expected 1 within %0d cycles", limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int hs, hs6, rel, base;
    rst_n = 1'b0; ARID = 4'd0; ARADDR = 10'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0;
    ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 80'({ARREADY, RVALID, RLAST, mem_rd_en, RRESP, RID}), 80'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0}));
    check("rst_rdata", 80'(RDATA), 80'(0));
    check("rst_mem_addr", 80'(mem_rd_addr), 80'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arready_idle", 80'(ARREADY), 80'(1));

    // Single INCR burst from word 2, RREADY held high
    RREADY = 1'b1; clear_logs();
    expect_beat(4'd3, 64'd2, 2'b00, 1'b0); expect_beat(4'd3, 64'd3, 2'b00, 1'b0);
    expect_beat(4'd3, 64'd4, 2'b00, 1'b0); expect_beat(4'd3, 64'd5, 2'b00, 1'b1);
    send_ar(4'd3, 10'h010, 8'd3, 3'd3, 2'b01, hs);
    wait_drain(100);
    check("t1_beats", 80'(acc_q.size()), 80'(4));
    if (rise_q.size() > 0) check("t1_first_latency", 80'(rise_q[0] - hs), 80'(4));
    for (int i = 1; i < acc_q.size(); i++) check("t1_beat_spacing", 80'(acc_q[i] - acc_q[i-1]), 80'(3));
    check("t1_reads", 80'(rd_cnt), 80'(4));

    // FIXED burst on word 5
    clear_logs();
    expect_beat(4'd5, 64'd5, 2'b00, 1'b0); expect_beat(4'd5, 64'd5, 2'b00, 1'b0);
    expect_beat(4'd5, 64'd5, 2'b00, 1'b1);
    send_ar(4'd5, 10'h028, 8'd2, 3'd3, 2'b00, hs);
    wait_drain(100);
    check("t2_reads", 80'(rd_cnt), 80'(3));
    foreach (rd_addr_q[i]) check("t2_fixed_addr", 80'(rd_addr_q[i]), 80'(5));

    // Burst running off the end of memory
    clear_logs();
    expect_beat(4'd7, 64'd63, 2'b00, 1'b0); expect_beat(4'd7, 64'd0, 2'b10, 1'b1);
    send_ar(4'd7, 10'h1F8, 8'd1, 3'd3, 2'b01, hs);
    wait_drain(100);
    check("t3_oor_reads", 80'(rd_cnt), 80'(1));
    if (rd_addr_q.size() > 0) check("t3_oor_addr", 80'(rd_addr_q[0]), 80'(63));

    // Unsupported burst type and oversized beat: error beats, no memory reads
    clear_logs();
    expect_beat(4'd8, 64'd0, 2'b10, 1'b0); expect_beat(4'd8, 64'd0, 2'b10, 1'b1);
    expect_beat(4'd10, 64'd0, 2'b10, 1'b1);
    send_ar(4'd8, 10'h000, 8'd1, 3'd3, 2'b10, hs);
    send_ar(4'd10, 10'h000, 8'd0, 3'd4, 2'b01, hs);
    wait_drain(100);
    check("t3_err_reads", 80'(rd_cnt), 80'(0));

    // Backpressure: RREADY 0,0,1 per beat
    RREADY = 1'b0; clear_logs();
    expect_beat(4'd9, 64'd0, 2'b00, 1'b0); expect_beat(4'd9, 64'd1, 2'b00, 1'b0);
    expect_beat(4'd9, 64'd2, 2'b00, 1'b1);
    send_ar(4'd9, 10'h000, 8'd2, 3'd3, 2'b01, hs);
    for (int b = 0; b < 3; b++) begin
      wait_rvalid(50);
      repeat (2) @(posedge clk);
      #1; RREADY = 1'b1;
      @(posedge clk); #1; RREADY = 1'b0;
    end
    wait_drain(20);
    check("t4_beats", 80'(acc_q.size()), 80'(3));
    check("t4_reads", 80'(rd_cnt), 80'(3));

    // Queue full: five ARs fill active burst plus queue, sixth waits
    clear_logs();
    for (int k = 1; k <= 6; k++) expect_beat(4'(k), 64'(k), 2'b00, 1'b1);
    for (int k = 1; k <= 5; k++) send_ar(4'(k), 10'(k * 8), 8'd0, 3'd3, 2'b01, hs);
    @(posedge clk); #1;
    check("t5_full", 80'(ARREADY), 80'(0));
    fork
      send_ar(4'd6, 10'h030, 8'd0, 3'd3, 2'b01, hs6);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("t5_full_hold", 80'(ARREADY), 80'(0));
        rel = cyc;
        RREADY = 1'b1;
      end
    join
    check("t5_ar6_after_release", 80'(hs6 > rel), 80'(1));
    wait_drain(200);
    check("t5_beats", 80'(acc_q.size()), 80'(6));

    // Reset during beat 2 of a 4-beat burst
    RREADY = 1'b0; clear_logs();
    expect_beat(4'd11, 64'd0, 2'b00, 1'b0);
    send_ar(4'd11, 10'h000, 8'd3, 3'd3, 2'b01, hs);
    wait_rvalid(50);
    RREADY = 1'b1;
    @(posedge clk); #1; RREADY = 1'b0;
    wait_rvalid(50);
    #1; rst_n = 1'b0;
    #1;
    check("t6_rvalid_async", 80'(RVALID), 80'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_arready", 80'(ARREADY), 80'(1));
    base = acc_total;
    RREADY = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_residual", 80'(acc_total), 80'(base));
    expect_beat(4'd12, 64'd3, 2'b00, 1'b0); expect_beat(4'd12, 64'd4, 2'b00, 1'b1);
    send_ar(4'd12, 10'h018, 8'd1, 3'd3, 2'b01, hs);
    wait_drain(100);
    check("t6_new_burst", 80'(acc_total), 80'(base + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_read_resp.md
# axi_read_resp

AXI4 read-channel responder (subordinate) serving the read address and read data channels that the LSU-side read initiator drives. Accepts AR requests into a 4-entry queue, walks each burst beat by beat against a synchronous single-port word memory, and returns R beats with RID, RRESP and RLAST. Serves as the DRAM-side endpoint in the accelerator subsystem and as the memory model in system benches.

## Interface
- ARID_WIDTH, 4, AXI ID width.
- ARADDR_WIDTH, 10, byte address width.
- RDATA_WIDTH, 64, data width; bytes per word BPW = RDATA_WIDTH/8, WSH = log2(BPW).
- MEM_WORDS, 64, implemented words. A word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ARID  in  ARID_WIDTH  request ID
- ARADDR  in  ARADDR_WIDTH  start byte address
- ARLEN  in  8  beats-1
- ARSIZE  in  3  log2 bytes per beat
- ARBURST  in  2  00 FIXED, 01 INCR, others unsupported
- ARVALID  in  1  request valid
- ARREADY  out  1  queue not full
- RID  out  ARID_WIDTH  ID of the current burst
- RDATA  out  RDATA_WIDTH  beat data
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat
- RVALID  out  1  beat valid
- RREADY  in  1  initiator accepts beat
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ARADDR_WIDTH-WSH  word index
- mem_rd_data  in  RDATA_WIDTH  data, valid the cycle after mem_rd_en

## Operation
- AR queue: 4-entry FIFO of {ID, ADDR, LEN, SIZE, BURST}. Push on ARVALID&ARREADY. ARREADY = ~full, with no bypass: a push is refused when full even if a pop occurs in the same cycle.
- FSM states: IDLE, FETCH, WAIT, SEND.
  - IDLE: if queue not empty, pop the head into the burst context (cur_id, cur_addr, len, size, burst), clear beat_cnt, and go to FETCH. Compute err once per burst: err = (ARSIZE > WSH) | ARBURST[1].
  - FETCH: mem_rd_addr = cur_addr >> WSH. mem_rd_en = 1 only if ~err and the word index is < MEM_WORDS. Go to WAIT.
  - WAIT: at the edge, latch RDATA = mem_rd_data when the read was issued, else 0. Latch RRESP = 10 if err or the index is out of range, else 00. Latch RID = cur_id and RLAST = (beat_cnt == len). Set RVALID and go to SEND.
  - SEND: RVALID held; RDATA, RRESP, RID and RLAST are held stable until RREADY.
    - On RREADY with RLAST: drop RVALID and go to IDLE.
    - On RREADY otherwise: beat_cnt += 1. cur_addr += (1 << size) for INCR (wraps modulo 2^ARADDR_WIDTH), unchanged for FIXED. Go to FETCH.
- If ARSIZE < WSH, consecutive beats may read the same word; the full word is returned each time.
- Out-of-range and error beats keep identical timing and still end the burst with RLAST.
- Bursts are served strictly in order; there is no interleaving.

## Timing
- Reset values: ARREADY = 1 after reset (queue empty). RVALID, RLAST, mem_rd_en = 0. RDATA, RID, RRESP, mem_rd_addr = 0. FSM = IDLE, queue empty, beat_cnt = 0.
- The first RVALID of a burst rises 4 edges after the AR handshake edge when the FSM was IDLE: pop, then FETCH, WAIT, SEND.
- Each beat costs 3 cycles when RREADY is held high (SEND -> FETCH -> WAIT -> SEND).
- After RLAST is accepted, 1 idle cycle passes before the next queued burst's FETCH.
- RREADY low stalls indefinitely in SEND. No memory read is issued during a stall.
- Reset asserted mid-burst clears RVALID immediately. The queue and burst context are discarded with no partial completion.
- ARLEN = 255 yields 256 beats. beat_cnt is 8 bits and never overflows because the compare precedes the increment.

## Test plan
- Single INCR burst: ARID=3, ARADDR=0x010, ARLEN=3, ARSIZE=3, memory word i = i, RREADY=1 -> 4 beats with RDATA 2,3,4,5, RID=3, RRESP=00, RLAST only on beat 4, first RVALID 4 edges after the handshake, 3-cycle beat spacing.
- FIXED burst: ARADDR=0x028, ARLEN=2, ARBURST=00 -> 3 beats, all RDATA=5, mem_rd_addr=5 each time.
- Out of range and unsupported: ARADDR=0x1F8, ARLEN=1, INCR, size 3 -> beat 1 returns word 63 with RRESP 00, beat 2 (index 64) returns RDATA 0 with RRESP 10 and RLAST. A separate request with ARBURST=10 -> every beat has RRESP=10 and no mem_rd_en.
- Backpressure: RREADY toggled 0,0,1 per beat -> RDATA, RID, RRESP and RLAST stay stable while stalled, no extra mem_rd_en, beat count unchanged.
- Queue full: 6 back-to-back ARs with RREADY=0 -> 1 burst active plus 4 queued, ARREADY low from then on. Releasing RREADY returns all 5 IDs in order. The sixth AR is accepted only once ARREADY rises again.
- Reset mid-burst: assert rst_n=0 during beat 2 of a 4-beat burst -> RVALID drops asynchronously. After release ARREADY=1, there are no residual beats, and a new burst completes normally.
